// File: rtl/pipe_arb_ctrl.sv
// Two-requester round-robin arbiter feeding a three-stage f=a&b / g=c|(a&b) pipeline.
// Optional per-requester result counters are built when PIPE_ARB_STATS_EN is defined.
module pipe_arb_ctrl #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] c0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [W-1:0] c1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [W-1:0] res_f,
  output logic [W-1:0] res_g,
  output logic         busy
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
`endif
);

  logic         stall;
  logic         last_id;
  logic         s1_v, s2_v;
  logic         s1_id, s2_id;
  logic [W-1:0] s1_t, s2_t;
  logic [W-1:0] s1_c, s2_c;
  logic [W-1:0] sel_a, sel_b, sel_c;

  assign stall = res_valid & ~res_ready;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !stall) begin
      gnt0 = req0 & (~req1 | last_id);
      gnt1 = req1 & (~req0 | ~last_id);
    end
  end

  assign sel_a = gnt1 ? a1 : a0;
  assign sel_b = gnt1 ? b1 : b0;
  assign sel_c = gnt1 ? c1 : c0;
  assign busy  = s1_v | s2_v | res_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id   <= 1'b1;
      s1_v      <= 1'b0;
      s1_id     <= 1'b0;
      s1_t      <= '0;
      s1_c      <= '0;
      s2_v      <= 1'b0;
      s2_id     <= 1'b0;
      s2_t      <= '0;
      s2_c      <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_f     <= '0;
      res_g     <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        last_id <= gnt1;
      end
      if (!stall) begin
        s1_v      <= gnt0 | gnt1;
        s1_id     <= gnt1;
        s1_t      <= (gnt0 | gnt1) ? (sel_a & sel_b) : '0;
        s1_c      <= (gnt0 | gnt1) ? sel_c : '0;
        s2_v      <= s1_v;
        s2_id     <= s1_id;
        s2_t      <= s1_t;
        s2_c      <= s1_c;
        // A bubble arriving at the output stage clears the visible result.
        res_valid <= s2_v;
        res_id    <= s2_v & s2_id;
        res_f     <= s2_v ? s2_t : '0;
        res_g     <= s2_v ? (s2_c | s2_t) : '0;
      end
    end
  end

`ifdef PIPE_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else if (res_valid && res_ready) begin
      if (!res_id && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if (res_id && cnt1 != 8'hFF)  cnt1 <= cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_arb_ctrl.sv
// Randomized bench for pipe_arb_ctrl against an op-level reference model.
// Also exercises the PIPE_ARB_STATS_EN counters when that macro is defined.
module tb_pipe_arb_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
  logic         gnt0, gnt1, res_valid, res_id, busy;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_f, res_g;
`ifdef PIPE_ARB_STATS_EN
  logic [7:0]   cnt0, cnt1;
`endif

  pipe_arb_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .c0(c0), .a1(a1), .b1(b1), .c1(c1),
    .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_f(res_f), .res_g(res_g), .busy(busy)
`ifdef PIPE_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ops in flight, indexed by age (0 = newest, 2 = at output).
  bit           mv [3];
  bit           mid[3];
  logic [W-1:0] ma [3], mb[3], mc[3];
  bit           m_last;
  int           m_cnt[2];
  bit           p0, p1;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mid[k] = 0; ma[k] = '0; mb[k] = '0; mc[k] = '0;
    end
    m_last   = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    bit stall, eg0, eg1;
    #1;
    if (rst) model_reset();
    stall = mv[2] && !res_ready;
    eg0 = !rst && !stall && req0 && (!req1 || m_last);
    eg1 = !rst && !stall && req1 && (!req0 || !m_last);
    check_eq("gnt0", gnt0, eg0);
    check_eq("gnt1", gnt1, eg1);
    check_eq("res_valid", res_valid, mv[2]);
    check_eq("res_id", res_id, mv[2] ? mid[2] : 1'b0);
    check_eq("res_f", res_f, mv[2] ? (ma[2] & mb[2]) : '0);
    check_eq("res_g", res_g, mv[2] ? (mc[2] | (ma[2] & mb[2])) : '0);
    check_eq("busy", busy, mv[0] | mv[1] | mv[2]);
`ifdef PIPE_ARB_STATS_EN
    check_eq("cnt0", cnt0, m_cnt[0]);
    check_eq("cnt1", cnt1, m_cnt[1]);
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (mv[2] && res_ready && m_cnt[mid[2]] < 255) m_cnt[mid[2]]++;
      if (!stall) begin
        for (int k = 2; k > 0; k--) begin
          mv[k] = mv[k-1]; mid[k] = mid[k-1];
          ma[k] = ma[k-1]; mb[k] = mb[k-1]; mc[k] = mc[k-1];
        end
        mv[0]  = eg0 | eg1;
        mid[0] = eg1;
        ma[0]  = eg1 ? a1 : a0;
        mb[0]  = eg1 ? b1 : b0;
        mc[0]  = eg1 ? c1 : c0;
      end
      if (eg0 | eg1) m_last = eg1;
      if (eg0) p0 = 0;
      if (eg1) p1 = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    p0 = 0;
    p1 = 0;
    @(negedge clk);
    req0 = 1; req1 = 1;
    step();                                   // reset state, no grants under reset
    rst = 0;

    a0 = 8'hAA; b0 = 8'h0F; c0 = 8'h40;
    a1 = 8'hF0; b1 = 8'h3C; c1 = 8'h01;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("arb_seq", gnt1, i % 2);
      step();
    end
    req0 = 0; req1 = 0;
    #1;
    check_eq("fixed_f", res_f, 8'h30);
    check_eq("fixed_g", res_g, 8'h31);
    check_eq("fixed_id", res_id, 1);
    step();

    rst = 1; req0 = 1; req1 = 1;              // reset with pipeline full
    #1 check_eq("rst_busy", busy, 0);
    step();
    rst = 0;
    #1 check_eq("post_rst_gnt0", gnt0, 1);
    step();
    req0 = 0; req1 = 0;
    repeat (4) step();

    for (int i = 0; i < 2000; i++) begin
      if (!p0 && ($urandom % 3 != 0)) begin
        p0 = 1; a0 = W'($urandom); b0 = W'($urandom); c0 = W'($urandom);
      end
      if (!p1 && ($urandom % 3 != 0)) begin
        p1 = 1; a1 = W'($urandom); b1 = W'($urandom); c1 = W'($urandom);
      end
      req0 = p0;
      req1 = p1;
      res_ready = ($urandom % 4 != 0);
      rst = (i == 1000);
      step();
    end
    rst = 0;
    req0 = 0; req1 = 0; res_ready = 1;
    repeat (4) step();

`ifdef PIPE_ARB_STATS_EN
    rst = 1;
    step();
    rst = 0;
    req0 = 1;
    for (int i = 0; i < 303; i++) begin
      a0 = W'($urandom); b0 = W'($urandom); c0 = W'($urandom);
      step();
    end
    req0 = 0;
    repeat (4) step();
    check_eq("cnt0_sat", cnt0, 255);
    check_eq("cnt1_zero", cnt1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule
